// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the scoreboard hazard unit.
// Thresholds are measured in cycles until a pending result reaches ID.
package hazard_pkg;

    localparam int REG_AW     = 5;
    localparam int THR_BRANCH = 1;
    localparam int THR_ALU    = 2;
    localparam int LAT_ALU    = 1;

    typedef enum logic [2:0] {
        MODE_RESET,
        MODE_EXC,
        MODE_BUSY,
        MODE_HAZ,
        MODE_RUN
    } mode_e;

    function automatic int cnt_width(input int load_lat);
        return $clog2(load_lat + 2);
    endfunction

    function automatic int LAT_LOAD(input int load_lat);
        return load_lat + 1;
    endfunction

endpackage

// File: rtl/hazard_detection_sb_scoreboard.sv
// Per-register countdown of cycles until a pending write is forwardable.
// Register 0 is never pending.
module reg_scoreboard #(
    parameter int NREGS  = 32,
    parameter int REG_AW = 5,
    parameter int CW     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze_i,
    input  logic              clear_i,
    input  logic              issue_i,
    input  logic [REG_AW-1:0] issue_rd_i,
    input  logic [CW-1:0]     issue_val_i,
    input  logic [REG_AW-1:0] ra_a_i,
    input  logic [REG_AW-1:0] ra_b_i,
    output logic [CW-1:0]     rd_a_o,
    output logic [CW-1:0]     rd_b_o
);

    logic [CW-1:0] cnt_q [NREGS];
    logic [CW-1:0] cnt_d [NREGS];

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (clear_i) begin
                cnt_d[r] = '0;
            end else if (!freeze_i) begin
                if (cnt_q[r] != '0)
                    cnt_d[r] = cnt_q[r] - CW'(1);
                // newest producer overrides the older countdown
                if (issue_i && issue_rd_i == REG_AW'(r))
                    cnt_d[r] = issue_val_i;
            end
        end
        cnt_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++)
                cnt_q[r] <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++)
                cnt_q[r] <= cnt_d[r];
        end
    end

    assign rd_a_o = cnt_q[ra_a_i];
    assign rd_b_o = cnt_q[ra_b_i];

endmodule

// File: rtl/hazard_detection_sb.sv
// Scoreboard hazard unit for a 5-stage pipeline resolving branches in ID.
// Drives stall/flush controls and counts data-hazard stall cycles.
module hazard_detection_sb #(
    parameter int NREGS    = 32,
    parameter int REG_AW   = hazard_pkg::REG_AW,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_beq,
    input  logic              id_bne,
    input  logic              id_equal,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              mem_busy,
    input  logic              exc_req,
    output logic              stall,
    output logic              idflush,
    output logic              ifflush,
    output logic              exflush,
    output logic              branch_taken,
    output logic [CNT_W-1:0]  stall_count
);
    import hazard_pkg::*;

    localparam int CW = cnt_width(LOAD_LAT);

    logic [CW-1:0]    cnt_rs, cnt_rt, thr, issue_val;
    logic             haz, taken, freeze, clear, issue;
    mode_e            mode;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    reg_scoreboard #(
        .NREGS (NREGS),
        .REG_AW(REG_AW),
        .CW    (CW)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .freeze_i   (freeze),
        .clear_i    (clear),
        .issue_i    (issue),
        .issue_rd_i (id_rd),
        .issue_val_i(issue_val),
        .ra_a_i     (id_rs),
        .ra_b_i     (id_rt),
        .rd_a_o     (cnt_rs),
        .rd_b_o     (cnt_rt)
    );

    assign thr = (id_beq | id_bne) ? CW'(THR_BRANCH) : CW'(THR_ALU);
    assign haz = id_valid &
        ((id_uses_rs & (id_rs != '0) & (cnt_rs >= thr)) |
         (id_uses_rt & (id_rt != '0) & (cnt_rt >= thr)));
    assign taken = id_valid &
        ((id_beq & id_equal) | (id_bne & ~id_equal));
    assign issue_val = id_memread ? CW'(LAT_LOAD(LOAD_LAT)) : CW'(LAT_ALU);

    always_comb begin
        if (rst)           mode = MODE_RESET;
        else if (exc_req)  mode = MODE_EXC;
        else if (mem_busy) mode = MODE_BUSY;
        else if (haz)      mode = MODE_HAZ;
        else               mode = MODE_RUN;
    end

    always_comb begin
        stall        = 1'b0;
        idflush      = 1'b0;
        ifflush      = 1'b0;
        exflush      = 1'b0;
        branch_taken = 1'b0;
        freeze       = 1'b0;
        clear        = 1'b0;
        issue        = 1'b0;
        unique case (mode)
            MODE_RESET: ;
            MODE_EXC: begin
                ifflush = 1'b1;
                idflush = 1'b1;
                exflush = 1'b1;
                clear   = 1'b1;
            end
            MODE_BUSY: begin
                stall  = 1'b1;
                freeze = 1'b1;
            end
            MODE_HAZ: begin
                stall   = 1'b1;
                idflush = 1'b1;
            end
            MODE_RUN: begin
                branch_taken = taken;
                ifflush      = taken;
                issue        = id_valid & id_regwrite & (id_rd != '0);
            end
            default: ;
        endcase
    end

    assign stall_count_d = (mode == MODE_HAZ && stall_count_q != '1)
                         ? stall_count_q + CNT_W'(1) : stall_count_q;

    always_ff @(posedge clk) begin
        if (rst) stall_count_q <= '0;
        else     stall_count_q <= stall_count_d;
    end

    assign stall_count = rst ? '0 : stall_count_q;

endmodule

// File: tb/tb_hazard_detection_sb.sv
// Scoreboard bench for hazard_detection_sb with LOAD_LAT=1 and LOAD_LAT=3.
module tb_hazard_detection_sb;

    typedef struct packed {
        logic       rst;
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       urs, urt, beq, bne, eq, rw, mr, busy, exc;
    } stim_t;

    typedef struct packed {
        logic [4:0]  fl;
        logic [15:0] sc;
    } exp_t;

    localparam logic [4:0] E0 = 5'b00000;
    localparam logic [4:0] EH = 5'b11000;
    localparam logic [4:0] EB = 5'b10000;
    localparam logic [4:0] EX = 5'b01110;
    localparam logic [4:0] ET = 5'b00101;

    logic       clk = 1'b0;
    logic       rst, id_valid, id_uses_rs, id_uses_rt, id_beq, id_bne;
    logic       id_equal, id_regwrite, id_memread, mem_busy, exc_req;
    logic [4:0] id_rs, id_rt, id_rd;

    logic        st1, idf1, iff1, exf1, bt1;
    logic        st3, idf3, iff3, exf3, bt3;
    logic [15:0] sc1, sc3;
    exp_t        obs1, obs3;

    exp_t        sbq [$];
    stim_t       stq [$];
    logic [4:0]  flq [$];
    logic [15:0] exp_sc;
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    hazard_detection_sb #(.LOAD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_beq(id_beq), .id_bne(id_bne), .id_equal(id_equal),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_rd(id_rd), .mem_busy(mem_busy), .exc_req(exc_req),
        .stall(st1), .idflush(idf1), .ifflush(iff1),
        .exflush(exf1), .branch_taken(bt1), .stall_count(sc1)
    );

    hazard_detection_sb #(.LOAD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_beq(id_beq), .id_bne(id_bne), .id_equal(id_equal),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_rd(id_rd), .mem_busy(mem_busy), .exc_req(exc_req),
        .stall(st3), .idflush(idf3), .ifflush(iff3),
        .exflush(exf3), .branch_taken(bt3), .stall_count(sc3)
    );

    assign obs1 = {st1, idf1, iff1, exf1, bt1, sc1};
    assign obs3 = {st3, idf3, iff3, exf3, bt3, sc3};

    function automatic stim_t s_idle();
        stim_t s = '0;
        return s;
    endfunction

    function automatic stim_t s_rst();
        stim_t s = '0;
        s.rst = 1'b1;
        return s;
    endfunction

    function automatic stim_t s_lw(input logic [4:0] rd, input logic [4:0] rs);
        stim_t s = '0;
        s.v = 1'b1; s.rs = rs; s.urs = 1'b1;
        s.rw = 1'b1; s.mr = 1'b1; s.rd = rd;
        return s;
    endfunction

    function automatic stim_t s_alu(input logic [4:0] rd, input logic [4:0] rs,
                                    input logic [4:0] rt);
        stim_t s = '0;
        s.v = 1'b1; s.rs = rs; s.rt = rt; s.urs = 1'b1; s.urt = 1'b1;
        s.rw = 1'b1; s.rd = rd;
        return s;
    endfunction

    function automatic stim_t s_br(input logic [4:0] rs, input logic [4:0] rt,
                                   input logic bne, input logic eq);
        stim_t s = '0;
        s.v = 1'b1; s.rs = rs; s.rt = rt; s.urs = 1'b1; s.urt = 1'b1;
        s.beq = ~bne; s.bne = bne; s.eq = eq;
        return s;
    endfunction

    function automatic void plan(input stim_t s, input logic [4:0] f);
        stq.push_back(s);
        flq.push_back(f);
    endfunction

    // Applies one cycle of stimulus and records what the DUT must show.
    task automatic drive(input stim_t s, input logic [4:0] f);
        rst = s.rst; id_valid = s.v; id_rs = s.rs; id_rt = s.rt;
        id_rd = s.rd; id_uses_rs = s.urs; id_uses_rt = s.urt;
        id_beq = s.beq; id_bne = s.bne; id_equal = s.eq;
        id_regwrite = s.rw; id_memread = s.mr;
        mem_busy = s.busy; exc_req = s.exc;
        sbq.push_back({f, s.rst ? 16'd0 : exp_sc});
        if (s.rst) exp_sc = '0;
        else if (f == EH) exp_sc = exp_sc + 16'd1;
    endtask

    task automatic test_reset();
        stim_t s;
        exp_t  e;
        s = s_br(5'd0, 5'd0, 1'b0, 1'b1);
        s.rst = 1'b1; s.exc = 1'b1;
        plan(s, E0);
        s = s_lw(5'd1, 5'd0);
        s.rst = 1'b1; s.busy = 1'b1;
        plan(s, E0);
        plan(s_idle(), E0);
        for (int i = 0; stq.size() > 0; i++) begin
            drive(stq.pop_front(), flq.pop_front());
            @(negedge clk);
            e = sbq.pop_front();
            n_checks += 2;
            if (obs1 !== e) $display("FAIL reset lat1 step %0d: got %h required %h", i, obs1, e);
            else n_pass++;
            if (obs3 !== e) $display("FAIL reset lat3 step %0d: got %h required %h", i, obs3, e);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        exp_t e;
        plan(s_rst(), E0);
        plan(s_lw(5'd1, 5'd0), E0);
        plan(s_alu(5'd7, 5'd1, 5'd1), EH);
        plan(s_alu(5'd7, 5'd1, 5'd1), E0);
        plan(s_idle(), E0);
        for (int i = 0; stq.size() > 0; i++) begin
            drive(stq.pop_front(), flq.pop_front());
            @(negedge clk);
            e = sbq.pop_front();
            n_checks++;
            if (obs1 !== e) $display("FAIL load_use step %0d: got %h required %h", i, obs1, e);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        exp_t e;
        plan(s_rst(), E0);
        plan(s_alu(5'd2, 5'd0, 5'd0), E0);
        plan(s_br(5'd2, 5'd0, 1'b0, 1'b0), EH);
        plan(s_br(5'd2, 5'd0, 1'b0, 1'b0), E0);
        plan(s_lw(5'd3, 5'd0), E0);
        plan(s_br(5'd3, 5'd3, 1'b0, 1'b0), EH);
        plan(s_br(5'd3, 5'd3, 1'b0, 1'b0), EH);
        plan(s_br(5'd3, 5'd3, 1'b0, 1'b0), E0);
        plan(s_br(5'd0, 5'd0, 1'b0, 1'b1), ET);
        plan(s_idle(), E0);
        for (int i = 0; stq.size() > 0; i++) begin
            drive(stq.pop_front(), flq.pop_front());
            @(negedge clk);
            e = sbq.pop_front();
            n_checks++;
            if (obs1 !== e) $display("FAIL branch step %0d: got %h required %h", i, obs1, e);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_long_load_waw();
        exp_t e;
        plan(s_rst(), E0);
        plan(s_lw(5'd4, 5'd0), E0);
        plan(s_alu(5'd8, 5'd4, 5'd0), EH);
        plan(s_alu(5'd8, 5'd4, 5'd0), EH);
        plan(s_alu(5'd8, 5'd4, 5'd0), EH);
        plan(s_alu(5'd8, 5'd4, 5'd0), E0);
        plan(s_lw(5'd5, 5'd0), E0);
        plan(s_alu(5'd5, 5'd0, 5'd0), E0);
        plan(s_alu(5'd9, 5'd5, 5'd5), E0);
        plan(s_idle(), E0);
        for (int i = 0; stq.size() > 0; i++) begin
            drive(stq.pop_front(), flq.pop_front());
            @(negedge clk);
            e = sbq.pop_front();
            n_checks++;
            if (obs3 !== e) $display("FAIL long_load_waw step %0d: got %h required %h", i, obs3, e);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_busy();
        stim_t s;
        exp_t  e;
        plan(s_rst(), E0);
        plan(s_lw(5'd6, 5'd0), E0);
        s = s_alu(5'd10, 5'd6, 5'd0);
        s.busy = 1'b1;
        for (int k = 0; k < 4; k++) plan(s, EB);
        for (int k = 0; k < 3; k++) plan(s_alu(5'd10, 5'd6, 5'd0), EH);
        plan(s_alu(5'd10, 5'd6, 5'd0), E0);
        plan(s_idle(), E0);
        for (int i = 0; stq.size() > 0; i++) begin
            drive(stq.pop_front(), flq.pop_front());
            @(negedge clk);
            e = sbq.pop_front();
            n_checks++;
            if (obs3 !== e) $display("FAIL mem_busy step %0d: got %h required %h", i, obs3, e);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_exception();
        stim_t s;
        exp_t  e;
        plan(s_rst(), E0);
        plan(s_lw(5'd6, 5'd0), E0);
        s = s_br(5'd6, 5'd6, 1'b0, 1'b1);
        s.exc = 1'b1; s.busy = 1'b1;
        plan(s, EX);
        plan(s_alu(5'd11, 5'd6, 5'd6), E0);
        plan(s_idle(), E0);
        for (int i = 0; stq.size() > 0; i++) begin
            drive(stq.pop_front(), flq.pop_front());
            @(negedge clk);
            e = sbq.pop_front();
            n_checks++;
            if (obs1 !== e) $display("FAIL exception step %0d: got %h required %h", i, obs1, e);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_zero_and_reset_mid_stall();
        stim_t s;
        exp_t  e;
        plan(s_rst(), E0);
        plan(s_lw(5'd0, 5'd0), E0);
        plan(s_alu(5'd12, 5'd0, 5'd0), E0);
        plan(s_br(5'd0, 5'd0, 1'b0, 1'b0), E0);
        plan(s_br(5'd0, 5'd0, 1'b1, 1'b0), ET);
        plan(s_lw(5'd13, 5'd0), E0);
        plan(s_alu(5'd14, 5'd13, 5'd0), EH);
        s = s_alu(5'd14, 5'd13, 5'd0);
        s.rst = 1'b1;
        plan(s, E0);
        plan(s_alu(5'd14, 5'd13, 5'd0), E0);
        plan(s_idle(), E0);
        for (int i = 0; stq.size() > 0; i++) begin
            drive(stq.pop_front(), flq.pop_front());
            @(negedge clk);
            e = sbq.pop_front();
            n_checks++;
            if (obs1 !== e) $display("FAIL zero_reset step %0d: got %h required %h", i, obs1, e);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        exp_sc = '0;
        drive(s_rst(), E0);
        void'(sbq.pop_front());
        @(posedge clk); #1;
        test_reset();
        test_load_use();
        test_branch();
        test_long_load_waw();
        test_mem_busy();
        test_exception();
        test_zero_and_reset_mid_stall();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
